// File: rtl/add_sub_accumulator_if.sv
// Command, result and adder-subtractor bus of add_sub_accumulator.
// The slave side is the accumulator. The master side is its environment:
// the command producer, the result consumer and the combinational adder-subtractor.
interface add_sub_accumulator_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    // Command handshake
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;

    // Adder-subtractor operands and result
    logic [WIDTH-1:0] as_a;
    logic [WIDTH-1:0] as_b;
    logic             as_cin;
    logic [WIDTH-1:0] as_sum;
    logic             as_cout;

    // Result handshake and flags
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic             zero;
    logic             ovf;
    logic [CNT_W-1:0] op_cnt;

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, as_sum, as_cout, res_ready,
        output cmd_ready, as_a, as_b, as_cin, res_valid, acc, carry, zero, ovf, op_cnt
    );

    modport master (
        output cmd_valid, cmd_op, cmd_data, as_sum, as_cout, res_ready,
        input  cmd_ready, as_a, as_b, as_cin, res_valid, acc, carry, zero, ovf, op_cnt
    );
endinterface

// File: rtl/add_sub_accumulator.sv
// add_sub_accumulator: sequential accumulator wrapped around an external
// combinational adder-subtractor. It feeds the adder from registers
// (a = accumulator, b = command data, cin = subtract), captures sum/cout
// back into the accumulator, and returns flags over a valid/ready handshake.
//
// Optional build macro ACC_SAT_EN: when defined, ADD/SUB results saturate
// (ADD carry-out -> all-ones, SUB borrow -> zero). The carry and ovf flags
// still reflect the raw adder result. When undefined, results wrap.
module add_sub_accumulator #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    add_sub_accumulator_if.slave bus
);

    localparam logic [1:0] OP_CLEAR = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_ADD   = 2'b10;
    localparam logic [1:0] OP_SUB   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_RESP
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] as_a_q, as_a_d;
    logic [WIDTH-1:0] as_b_q, as_b_d;
    logic             as_cin_q, as_cin_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] op_cnt_q, op_cnt_d;

    // The completed-operation counter sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Two's-complement overflow from operand and result sign bits.
    // For subtract, b is effectively negated, so overflow needs opposite signs.
    function automatic logic ovf_of(input logic sub, input logic a_msb,
                                    input logic b_msb, input logic s_msb);
        if (sub)
            return (a_msb != b_msb) && (s_msb != a_msb);
        else
            return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

`ifdef ACC_SAT_EN
    // Clamp on unsigned carry-out (ADD) or borrow (SUB), else pass the raw sum.
    function automatic logic [WIDTH-1:0] sat_capture(input logic sub, input logic cout,
                                                     input logic [WIDTH-1:0] sum);
        if (!sub && cout)
            return '1;
        if (sub && !cout)
            return '0;
        return sum;
    endfunction
`endif

    // Next-state and datapath update; everything holds unless the state says otherwise.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        as_a_d   = as_a_q;
        as_b_d   = as_b_q;
        as_cin_d = as_cin_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        op_cnt_d = op_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    case (bus.cmd_op)
                        OP_CLEAR: begin
                            acc_d   = '0;
                            carry_d = 1'b0;
                            ovf_d   = 1'b0;
                            state_d = S_RESP;
                        end
                        OP_LOAD: begin
                            acc_d   = bus.cmd_data;
                            carry_d = 1'b0;
                            ovf_d   = 1'b0;
                            state_d = S_RESP;
                        end
                        OP_ADD, OP_SUB: begin
                            as_a_d   = acc_q;
                            as_b_d   = bus.cmd_data;
                            as_cin_d = (bus.cmd_op == OP_SUB);
                            state_d  = S_ISSUE;
                        end
                    endcase
                end
            end
            // One cycle for the adder inputs to settle before sampling its outputs.
            S_ISSUE: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
`ifdef ACC_SAT_EN
                acc_d = sat_capture(as_cin_q, bus.as_cout, bus.as_sum);
`else
                acc_d = bus.as_sum;
`endif
                carry_d = bus.as_cout;
                ovf_d   = ovf_of(as_cin_q, as_a_q[WIDTH-1], as_b_q[WIDTH-1],
                                 bus.as_sum[WIDTH-1]);
                state_d = S_RESP;
            end
            S_RESP: begin
                if (bus.res_ready) begin
                    op_cnt_d = sat_inc(op_cnt_q);
                    state_d  = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register; reset also aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (!rst_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // Accumulator, flags, counter and adder operand registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q    <= '0;
            as_a_q   <= '0;
            as_b_q   <= '0;
            as_cin_q <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            op_cnt_q <= '0;
        end else begin
            acc_q    <= acc_d;
            as_a_q   <= as_a_d;
            as_b_q   <= as_b_d;
            as_cin_q <= as_cin_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            op_cnt_q <= op_cnt_d;
        end
    end

    assign bus.cmd_ready = (state_q == S_IDLE);
    assign bus.res_valid = (state_q == S_RESP);
    assign bus.as_a      = as_a_q;
    assign bus.as_b      = as_b_q;
    assign bus.as_cin    = as_cin_q;
    assign bus.acc       = acc_q;
    assign bus.carry     = carry_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = (acc_q == '0);
    assign bus.op_cnt    = op_cnt_q;

endmodule
